uart_tx_mmio: RTL and testbench

UART_TX_MMIO -- requirements
Module: uart_tx_mmio

---
 rtl/uart_tx_mmio.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a small transmit FIFO and a sticky overflow flag.
// Define SALAGA_UART_SIM_PRINT_EN to echo each accepted character to stdout in simulation.
module uart_tx_mmio #(
  parameter logic [31:0] MM_ADDR      = 32'h0000_0054,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ip_data_addr,
  input  logic        ip_data_wr,
  input  logic [3:0]  ip_data_mask,
  input  logic [31:0] ip_data_from_proc,
  input  logic        ip_data_rd,
  output logic        op_data_valid,
  output logic [31:0] op_data_to_proc,
  output logic        op_uart_tx
);

  localparam int unsigned   PtrW      = $clog2(FIFO_DEPTH);
  localparam logic [15:0]   BaudMax   = 16'(CLKS_PER_BIT - 1);
  localparam logic [PtrW:0] CountFull = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e        r_state;
  logic [15:0]   r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;

  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW:0] r_count;
  logic          r_ovf;

  logic w_addr_hit;
  logic w_store;
  logic w_rd_hit;
  logic w_full;
  logic w_empty;
  logic w_baud_end;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_tx_ready;
  logic w_tx_idle;
  logic w_unused;

  assign w_addr_hit = (ip_data_addr == MM_ADDR);
  assign w_store    = ip_data_wr && w_addr_hit && ip_data_mask[0];
  assign w_rd_hit   = ip_data_rd && w_addr_hit;
  assign w_full     = (r_count == CountFull);
  assign w_empty    = (r_count == '0);
  assign w_baud_end = (r_baud == BaudMax);

  // The FSM takes the head byte either from IDLE or at the very last STOP cycle (no idle gap).
  assign w_pop  = !w_empty && ((r_state == StIdle) || ((r_state == StStop) && w_baud_end));
  assign w_push = w_store && (!w_full || w_pop);
  assign w_drop = w_store && w_full && !w_pop;

  assign w_tx_ready = !w_full;
  assign w_tx_idle  = w_empty && (r_state == StIdle);

  assign op_data_valid   = w_rd_hit;
  assign op_data_to_proc = op_data_valid ? {29'b0, r_ovf, w_tx_idle, w_tx_ready} : 32'b0;
  assign op_uart_tx      = r_tx;

  assign w_unused = ^{ip_data_from_proc[31:8], ip_data_mask[3:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      // A drop on the same edge as a status read keeps the flag set.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (w_rd_hit) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= ip_data_from_proc[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_shift <= r_fifo[r_rd_ptr];
            r_baud  <= '0;
            r_tx    <= 1'b0;
            r_state <= StStart;
          end
        end
        StStart: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= StData;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        StData: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_bit   <= '0;
              r_tx    <= 1'b1;
              r_state <= StStop;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        StStop: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= r_fifo[r_rd_ptr];
              r_tx    <= 1'b0;
              r_state <= StStart;
            end else begin
              r_tx    <= 1'b1;
              r_state <= StIdle;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= StIdle;
        end
      endcase
    end
  end

`ifdef SALAGA_UART_SIM_PRINT_EN
  always @(posedge clk) begin
    if (reset && w_push) begin
      $write("%c", ip_data_from_proc[7:0]);
    end
  end
`else
`endif

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: vector table, hand-written corner sequences and random traffic
// checked against a frame-level queue model.
module tb_uart_tx_mmio;

  localparam logic [31:0] MM    = 32'h0000_0054;
  localparam int          Cpb   = 4;
  localparam int          Depth = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        wr;
  logic [3:0]  mask;
  logic [31:0] wdata;
  logic        rd;
  logic        valid;
  logic [31:0] rdata;
  logic        tx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_mmio #(
    .MM_ADDR     (MM),
    .CLKS_PER_BIT(Cpb),
    .FIFO_DEPTH  (Depth)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .ip_data_addr     (addr),
    .ip_data_wr       (wr),
    .ip_data_mask     (mask),
    .ip_data_from_proc(wdata),
    .ip_data_rd       (rd),
    .op_data_valid    (valid),
    .op_data_to_proc  (rdata),
    .op_uart_tx       (tx)
  );

  // Reference model: byte queue plus the start edge of the frame on the wire.
  logic [7:0] q[$];
  bit         m_active;
  int         m_fs;
  logic [7:0] m_cur;
  bit         m_ovf;
  int         cyc;

  logic        last_valid;
  logic [31:0] last_rdata;
  logic        last_tx;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic idle;
    logic ready;
    idle  = (q.size() == 0) && !m_active;
    ready = (q.size() < Depth);
    return {29'b0, m_ovf, idle, ready};
  endfunction

  function automatic logic frame_bit(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[slot-1];
  endfunction

  function automatic logic exp_tx();
    if (!m_active) return 1'b1;
    return frame_bit(m_cur, (cyc - m_fs) / Cpb);
  endfunction

  task automatic model_reset();
    q.delete();
    m_active = 0;
    m_ovf    = 0;
  endtask

  task automatic model_edge(input logic rst_n, input logic w, input logic r,
                            input logic [31:0] a, input logic [3:0] m, input logic [7:0] d);
    bit hit, frame_end, pop, st, push, drop;
    cyc++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    hit       = (a == MM);
    frame_end = m_active && (cyc - m_fs == 10 * Cpb);
    pop       = (q.size() > 0) && (!m_active || frame_end);
    st        = w && hit && m[0];
    push      = st && ((q.size() < Depth) || pop);
    drop      = st && !push;
    if (pop) begin
      m_cur    = q.pop_front();
      m_fs     = cyc;
      m_active = 1;
    end else if (frame_end) begin
      m_active = 0;
    end
    if (push) q.push_back(d);
    if (drop) m_ovf = 1;
    else if (r && hit) m_ovf = 0;
  endtask

  // One clock: drive at negedge, check load path, step model, sample tx at next negedge.
  task automatic tick(input logic w, input logic r, input logic [31:0] a,
                      input logic [3:0] m, input logic [7:0] d);
    wr    = w;
    rd    = r;
    addr  = a;
    mask  = m;
    wdata = {24'($urandom()), d};
    #1;
    last_valid = valid;
    last_rdata = rdata;
    chk("valid", 32'(valid), 32'(r && (a == MM)));
    chk("status", rdata, (r && (a == MM)) ? exp_status() : 32'h0);
    model_edge(reset, w, r, a, m, d);
    @(posedge clk);
    @(negedge clk);
    last_tx = tx;
    chk("tx", 32'(tx), 32'(exp_tx()));
  endtask

  task automatic idle_tick();
    tick(1'b0, 1'b0, MM, 4'b0000, 8'h00);
  endtask

  task automatic push_tick(input logic [7:0] d);
    tick(1'b1, 1'b0, MM, 4'b0001, d);
  endtask

  task automatic read_tick();
    tick(1'b0, 1'b1, MM, 4'b0000, 8'h00);
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [7:0]  data;
    logic        exp_valid;
    logic [31:0] exp_rdata;
    logic        exp_tx;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [9:0] pat;
    logic [7:0] bb[2];
    int lows;

    vecs[0] = '{1'b1, 1'b0, MM,          4'b1110, 8'h41, 1'b0, 32'h0, 1'b1};
    vecs[1] = '{1'b1, 1'b0, MM + 32'd4,  4'b1111, 8'h42, 1'b0, 32'h0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, MM,          4'b0000, 8'h00, 1'b1, 32'h3, 1'b1};
    vecs[3] = '{1'b0, 1'b1, MM + 32'd4,  4'b0000, 8'h00, 1'b0, 32'h0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, MM,          4'b0000, 8'h43, 1'b1, 32'h3, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 32'h0,       4'b0001, 8'h44, 1'b0, 32'h0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, MM,          4'b1111, 8'h00, 1'b1, 32'h3, 1'b1};

    cyc   = 0;
    reset = 1'b0;
    wr    = 1'b0;
    rd    = 1'b1;
    addr  = MM;
    mask  = 4'b0000;
    wdata = 32'h0;
    model_reset();
    @(negedge clk);
    #1;
    chk("reset_tx", 32'(tx), 32'h1);
    chk("reset_valid", 32'(valid), 32'h1);
    chk("reset_status", rdata, 32'h3);
    @(negedge clk);
    reset = 1'b1;
    idle_tick();

    // Ignored stores and plain reads while idle.
    for (int i = 0; i < 7; i++) begin
      tick(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].mask, vecs[i].data);
      chk("vec_valid", 32'(last_valid), 32'(vecs[i].exp_valid));
      chk("vec_rdata", last_rdata, vecs[i].exp_rdata);
      chk("vec_tx", 32'(last_tx), 32'(vecs[i].exp_tx));
    end
    for (int i = 0; i < 3; i++) idle_tick();
    read_tick();
    chk("no_push_status", last_rdata, 32'h3);

    // Single byte frame.
    pat = {1'b1, 8'h41, 1'b0};
    push_tick(8'h41);
    chk("push_edge_tx", 32'(last_tx), 32'h1);
    for (int i = 0; i < 10 * Cpb; i++) begin
      idle_tick();
      chk("frame41", 32'(last_tx), 32'(pat[i / Cpb]));
    end
    idle_tick();
    read_tick();
    chk("idle_after_frame", last_rdata, 32'h3);

    // Back-to-back frames, no gap.
    bb[0] = 8'h55;
    bb[1] = 8'hAA;
    push_tick(8'h55);
    push_tick(8'hAA);
    chk("b2b_start", 32'(last_tx), 32'h0);
    for (int i = 1; i < 20 * Cpb; i++) begin
      idle_tick();
      chk("b2b_bits", 32'(last_tx), 32'(frame_bit(bb[i / (10 * Cpb)], (i % (10 * Cpb)) / Cpb)));
    end
    idle_tick();
    read_tick();
    chk("b2b_idle", last_rdata, 32'h3);

    // Overflow: sixth consecutive store is dropped.
    for (int i = 0; i < 6; i++) push_tick(8'(8'h30 + i));
    read_tick();
    chk("ovf_status", last_rdata, 32'h4);
    read_tick();
    chk("ovf_cleared", last_rdata, 32'h0);
    for (int i = 0; i < 5 * 10 * Cpb + 10; i++) idle_tick();
    read_tick();
    chk("ovf_drained", last_rdata, 32'h3);

    // Full FIFO, push lands on the STOP->START pop edge.
    for (int i = 0; i < 5; i++) push_tick(8'(8'h61 + i));
    for (int i = 0; i < 10 * Cpb - 4; i++) idle_tick();
    tick(1'b1, 1'b1, MM, 4'b0001, 8'h7A);
    chk("full_pop_pre", last_rdata, 32'h0);
    read_tick();
    chk("full_pop_post", last_rdata, 32'h0);
    for (int i = 0; i < 5 * 10 * Cpb; i++) idle_tick();
    read_tick();
    chk("full_pop_drained", last_rdata, 32'h3);

    // Reset in the middle of a frame.
    push_tick(8'h00);
    for (int i = 0; i < 10; i++) idle_tick();
    chk("pre_rst_tx", 32'(last_tx), 32'h0);
    reset = 1'b0;
    rd    = 1'b1;
    addr  = MM;
    wr    = 1'b0;
    #1;
    chk("rst_tx_now", 32'(tx), 32'h1);
    chk("rst_status", rdata, 32'h3);
    model_reset();
    idle_tick();
    read_tick();
    chk("rst_hold_status", last_rdata, 32'h3);
    reset = 1'b1;
    lows  = 0;
    for (int i = 0; i < 60; i++) begin
      idle_tick();
      if (last_tx == 1'b0) lows++;
    end
    chk("no_residual_frame", 32'(lows), 32'h0);
    read_tick();
    chk("rst_release_status", last_rdata, 32'h3);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 3);
      if (sel < 2) a = MM;
      else if (sel == 2) a = MM + 32'd4;
      else a = $urandom();
      tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), a,
           4'($urandom()), 8'($urandom()));
    end
    for (int i = 0; i < 6 * 10 * Cpb; i++) idle_tick();
    read_tick();
    read_tick();
    chk("final_status", last_rdata, 32'h3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
